frame_parse: RTL and testbench
==============================

// Module: frame_parse
// PURPOSE
//  Receive-side counterpart of frame_assembly. Pops bytes from the eth RX FIFO over the i_rdata/i_rready/o_rreq handshake.
//  Decodes one frame into header fields plus a payload of up to MAX_PAYLOAD bytes, then reports it to the protocol FSM (mhp) as a 1-cycle pulse.
//  Frame byte order: dst[15:8], dst[7:0], src[15:8], src[7:0], size[15:8], size[7:0], {dir,type[6:0]}, then size payload bytes.
// PARAMETERS
//  MAX_PAYLOAD  42   max payload bytes stored; o_payload width = 8*MAX_PAYLOAD (336 at default)
//  TIMEOUT_CYC  255  idle cycles tolerated mid-frame before abort; counter width = $clog2(TIMEOUT_CYC+1)
// PORTS
//  i_clk           in   1       clock
//  i_rst           in   1       asynchronous reset, active-high
//  i_rdata         in   8       RX FIFO data; valid the cycle after the pop
//  i_rready        in   1       RX FIFO non-empty
//  o_rreq          out  1       FIFO pop request (combinational)
//  i_my_addr       in   16      local address (used only with FRAME_PARSE_ADDR_FILTER_EN)
//  o_busy          out  1       high from first pop until frame end or abort
//  o_valid         out  1       1-cycle pulse: good frame decoded
//  o_err           out  1       1-cycle pulse: oversize frame or timeout abort
//  o_drop          out  1       1-cycle pulse: frame filtered by address
//  o_dst, o_src    out  16 ea   decoded addresses
//  o_size          out  16      decoded size field
//  o_dir           out  1       bit 7 of header byte 6
//  o_type          out  7       bits 6:0 of header byte 6
//  o_payload       out  336     payload; byte 0 in [335:328]; unused bytes zero
//  o_payload_size  out  6       payload bytes stored (= size when valid)
// BEHAVIOUR
//  Reset (async): every output 0, FSM IDLE, counters 0. Reset mid-frame discards the partial frame and emits no pulse.
//  Pop: FIFO pops in each cycle with o_rreq=1. That byte is on i_rdata and captured at the end of the next cycle.
//   Pipelined: up to one pop per cycle.
//  o_rreq = i_rready & ~DONE & (req_cnt < 7 | (size_known & req_cnt < 7+size)).
//   Never over-pops past the frame end.
//   size_known is set when byte 5 is captured. req_cnt never exceeds 7 before that.
//  States:
//   IDLE -> HDR on the first pop (o_busy=1).
//   HDR: captures bytes 0..6 into shadow regs.
//    After byte 6: size==0 -> DONE; size>MAX_PAYLOAD -> DRAIN; else PAY.
//   PAY: stores payload bytes MSB-first at index rx_cnt-7; goes to DONE after the last byte.
//   DRAIN: pops and discards the remaining size bytes, then o_err=1 for 1 cycle and returns to IDLE.
//    Output fields are not updated.
//   DONE (1 cycle): copies shadow regs to the outputs, pulses o_valid (or o_drop when filtered), returns to IDLE.
//    A new frame may start popping the cycle after DONE.
//  Output fields hold their values from one o_valid until the next o_valid.
//  Payload shadow is zeroed at frame start.
//  o_valid, o_err and o_drop are mutually exclusive.
//  Timeout: a counter increments every busy cycle with no byte capture and clears on each capture.
//   When it reaches TIMEOUT_CYC: o_err pulse, go to IDLE, outputs unchanged.
//   Unread bytes stay in the FIFO. Resync is the upper layer's job.
//  A byte in flight (popped but not yet captured) is always captured before a DONE/DRAIN exit.
//   Timeout cannot fire with a pop outstanding.
//  size is 16 bits; the comparison against MAX_PAYLOAD uses the full 16 bits; DRAIN counts up to 65535.
// CONFIGURATION
//  FRAME_PARSE_ADDR_FILTER_EN defined:
//   - In DONE, if dst != i_my_addr and dst != 16'hFFFF: o_drop pulses instead of o_valid, and outputs are not updated.
//   - Oversize frames still give o_err regardless of dst.
//  FRAME_PARSE_ADDR_FILTER_EN undefined:
//   - Every good frame gives o_valid.
//   - o_drop is tied to 0 and i_my_addr is unused.
// TESTING
//  T1 FIFO holds FFFF 0001 0003 83 AA BB CC, i_rready stays high:
//   -> 10 consecutive pops.
//   -> o_valid the cycle after the last capture.
//   -> dst=FFFF, src=0001, dir=1, type=03, payload_size=3, o_payload[335:312]=AABBCC, rest 0.
//  T2 size=0 frame 0005 0002 0000 03
//   -> exactly 7 pops, o_valid, payload all zero.
//   -> The next frame queued behind it is not popped before DONE.
//  T3 size=50 (0032) frame
//   -> 57 pops total, o_err pulse, o_valid never high, outputs keep the T1 values.
//  T4 i_rready drops after 4 bytes for TIMEOUT_CYC cycles
//   -> o_err pulse, back to IDLE.
//   -> The same stall lasting TIMEOUT_CYC-1 cycles, then resumed, completes with o_valid.
//  T5 FRAME_PARSE_ADDR_FILTER_EN, i_my_addr=0007:
//   -> dst=0007 gives o_valid; dst=0009 gives o_drop; dst=FFFF gives o_valid.
//   -> Without the macro, dst=0009 gives o_valid.
//  T6 i_rst asserted mid-payload
//   -> all outputs 0 asynchronously, no pulse.
//   -> The next full frame after release parses correctly.

Source files
------------

// File: rtl/frame_parse.sv
// Receive-side frame parser: pops one frame from the RX FIFO, decodes header and payload, and
// reports it with a 1-cycle pulse. Optional address filter: define FRAME_PARSE_ADDR_FILTER_EN.
module frame_parse #(
    parameter int unsigned MAX_PAYLOAD = 42,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [7:0]                       i_rdata,
    input  logic                             i_rready,
    output logic                             o_rreq,
    input  logic [15:0]                      i_my_addr,
    output logic                             o_busy,
    output logic                             o_valid,
    output logic                             o_err,
    output logic                             o_drop,
    output logic [15:0]                      o_dst,
    output logic [15:0]                      o_src,
    output logic [15:0]                      o_size,
    output logic                             o_dir,
    output logic [6:0]                       o_type,
    output logic [8*MAX_PAYLOAD-1:0]         o_payload,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0] o_payload_size
);
    localparam int unsigned PW = 8 * MAX_PAYLOAD;
    localparam int unsigned SW = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {StIdle, StHdr, StPay, StDrain, StDone, StErr} state_t;
    state_t r_state, w_next;

    logic [16:0]   r_req_cnt, r_rx_cnt;
    logic          r_inflight, r_size_known;
    logic [TW-1:0] r_to_cnt;
    logic [15:0]   r_sh_dst, r_sh_src, r_sh_size;
    logic          r_sh_dir;
    logic [6:0]    r_sh_type;
    logic [PW-1:0] r_sh_pay;
    logic [15:0]   r_dst, r_src, r_size;
    logic          r_dir;
    logic [6:0]    r_type;
    logic [PW-1:0] r_pay;
    logic [SW-1:0] r_psize;

    logic        w_busy, w_cap, w_last, w_timeout, w_rreq, w_pass, w_load;
    logic [16:0] w_frame_len, w_pay_idx;

    assign w_frame_len = 17'd7 + {1'b0, r_sh_size};
    assign w_pay_idx   = r_rx_cnt - 17'd7;
    assign w_busy      = (r_state == StHdr) || (r_state == StPay) || (r_state == StDrain);
    assign w_cap       = r_inflight;
    assign w_last      = w_cap && (r_rx_cnt == w_frame_len - 17'd1);
    // A cycle without capture implies no pop is outstanding, so aborting here never strands a byte.
    assign w_timeout   = w_busy && !w_cap && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    assign w_rreq      = i_rready && !i_rst && !w_timeout &&
                         (w_busy || (r_state == StIdle)) &&
                         ((r_req_cnt < 17'd7) || (r_size_known && (r_req_cnt < w_frame_len)));
    assign o_rreq      = w_rreq;

`ifdef FRAME_PARSE_ADDR_FILTER_EN
    assign w_pass = (r_sh_dst == i_my_addr) || (r_sh_dst == 16'hFFFF);
`else
    logic w_unused_my_addr;
    assign w_unused_my_addr = ^i_my_addr;
    assign w_pass = 1'b1;
`endif
    assign w_load = (r_state == StDone) && w_pass;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle: if (w_rreq) w_next = StHdr;
            StHdr: begin
                if (w_timeout) w_next = StErr;
                else if (w_cap && (r_rx_cnt == 17'd6)) begin
                    if (r_sh_size == 16'd0)                  w_next = StDone;
                    else if (r_sh_size > 16'(MAX_PAYLOAD))   w_next = StDrain;
                    else                                     w_next = StPay;
                end
            end
            StPay:   if (w_timeout) w_next = StErr; else if (w_last) w_next = StDone;
            StDrain: if (w_timeout || w_last) w_next = StErr;
            StDone:  w_next = StIdle;
            StErr:   w_next = StIdle;
            default: w_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req_cnt <= '0; r_rx_cnt <= '0; r_inflight <= 1'b0; r_size_known <= 1'b0;
            r_to_cnt  <= '0;
            r_sh_dst  <= '0; r_sh_src <= '0; r_sh_size <= '0; r_sh_dir <= 1'b0;
            r_sh_type <= '0; r_sh_pay <= '0;
            r_dst <= '0; r_src <= '0; r_size <= '0; r_dir <= 1'b0; r_type <= '0;
            r_pay <= '0; r_psize <= '0;
        end else begin
            r_inflight <= w_rreq;
            if (w_rreq) r_req_cnt <= r_req_cnt + 17'd1;
            if ((r_state == StIdle) && w_rreq) r_sh_pay <= '0;
            if (w_cap) begin
                r_rx_cnt <= r_rx_cnt + 17'd1;
                r_to_cnt <= '0;
                case (r_rx_cnt)
                    17'd0: r_sh_dst[15:8]  <= i_rdata;
                    17'd1: r_sh_dst[7:0]   <= i_rdata;
                    17'd2: r_sh_src[15:8]  <= i_rdata;
                    17'd3: r_sh_src[7:0]   <= i_rdata;
                    17'd4: r_sh_size[15:8] <= i_rdata;
                    17'd5: begin
                        r_sh_size[7:0] <= i_rdata;
                        r_size_known   <= 1'b1;
                    end
                    17'd6: {r_sh_dir, r_sh_type} <= i_rdata;
                    default: begin
                        if (r_state == StPay) begin
                            for (int i = 0; i < int'(MAX_PAYLOAD); i++) begin
                                if (w_pay_idx == 17'(i)) r_sh_pay[PW-1-8*i -: 8] <= i_rdata;
                            end
                        end
                    end
                endcase
            end else if (w_busy) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if ((r_state == StDone) || (r_state == StErr)) begin
                r_req_cnt <= '0; r_rx_cnt <= '0; r_size_known <= 1'b0; r_to_cnt <= '0;
            end
            if (w_load) begin
                r_dst <= r_sh_dst; r_src <= r_sh_src; r_size <= r_sh_size; r_dir <= r_sh_dir;
                r_type <= r_sh_type; r_pay <= r_sh_pay; r_psize <= r_sh_size[SW-1:0];
            end
        end
    end

    // Fields show the new frame during its o_valid cycle and are held from then on.
    always_comb begin
        o_busy  = w_busy;
        o_valid = w_load;
        o_drop  = (r_state == StDone) && !w_pass;
        o_err   = (r_state == StErr);
        o_dst = r_dst; o_src = r_src; o_size = r_size; o_dir = r_dir; o_type = r_type;
        o_payload = r_pay; o_payload_size = r_psize;
        if (w_load) begin
            o_dst = r_sh_dst; o_src = r_sh_src; o_size = r_sh_size; o_dir = r_sh_dir;
            o_type = r_sh_type; o_payload = r_sh_pay; o_payload_size = r_sh_size[SW-1:0];
        end
    end
endmodule

// File: tb/tb_frame_parse.sv
// Self-checking bench for frame_parse: FIFO model on the input side, scoreboard of expected
// frame results, one task per scenario.
`timescale 1ns/1ps
module tb_frame_parse;
    localparam int MAXP = 42;
    localparam int TO   = 255;
`ifdef FRAME_PARSE_ADDR_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk = 1'b0, rst;
    logic [7:0] rdata;
    logic rready, rreq, busy, valid, err, drop, dir;
    logic [15:0] my_addr, dst, src, size;
    logic [6:0] typ;
    logic [8*MAXP-1:0] pay;
    logic [5:0] psize;

    frame_parse #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYC(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_rdata(rdata), .i_rready(rready), .o_rreq(rreq),
        .i_my_addr(my_addr), .o_busy(busy), .o_valid(valid), .o_err(err), .o_drop(drop),
        .o_dst(dst), .o_src(src), .o_size(size), .o_dir(dir), .o_type(typ),
        .o_payload(pay), .o_payload_size(psize)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                kind;   // 1 valid, 2 err, 3 drop
        logic [61:0]       flds;   // {dst, src, size, dir, type, payload_size}
        logic [8*MAXP-1:0] pay;
    } exp_t;

    exp_t sb[$];
    exp_t last_g, e;
    logic [7:0] q[$];
    int pop_cyc[$];
    int cyc = 0, n_pops = 0, n_cmp = 0, n_fail = 0;
    int stall_at = -1, stall_len = 0, stall_cnt = 0;
    int kind, pcyc, pcyc1;
    bit en = 1'b0, pend = 1'b0;
    logic [7:0] hold;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data appears the cycle after a pop
    initial begin
        rready = 1'b0; rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (pend) begin rdata = hold; pend = 1'b0; end
            if (en && q.size() > 0 && n_pops == stall_at && stall_cnt < stall_len) begin
                rready = 1'b0; stall_cnt++;
            end else rready = en && (q.size() > 0);
            #1;
            if (rreq && q.size() > 0) begin
                hold = q.pop_front(); pend = 1'b1; n_pops++; pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [7:0] pbyte(input logic [7:0] base, input logic [7:0] step, input int i);
        return base + step * 8'(i);
    endfunction

    task automatic push_frame(input logic [15:0] d, input logic [15:0] s, input logic [15:0] sz,
                              input logic dr, input logic [6:0] ty, input logic [7:0] base,
                              input logic [7:0] step, input bit abort);
        exp_t x;
        logic [8*MAXP-1:0] p = '0;
        q.push_back(d[15:8]); q.push_back(d[7:0]); q.push_back(s[15:8]); q.push_back(s[7:0]);
        q.push_back(sz[15:8]); q.push_back(sz[7:0]); q.push_back({dr, ty});
        for (int i = 0; i < int'(sz); i++) begin
            q.push_back(pbyte(base, step, i));
            if (i < MAXP) p[8*MAXP-1-8*i -: 8] = pbyte(base, step, i);
        end
        x = last_g;
        if (abort || sz > 16'(MAXP)) x.kind = 2;
        else if (FILT && d != my_addr && d != 16'hFFFF) x.kind = 3;
        else begin
            x.kind = 1; x.flds = {d, s, sz, dr, ty, sz[5:0]}; x.pay = p;
            last_g = x;
        end
        sb.push_back(x);
    endtask

    task automatic wait_pulse(input int budget, output int k, output int at);
        k = 0; at = -1;
        for (int i = 0; i < budget && k == 0; i++) begin
            @(posedge clk); #2;
            if (valid || err || drop) begin
                k = valid ? 1 : (err ? 2 : 3);
                if ($countones({valid, err, drop}) > 1) k = 4;
                at = cyc;
            end
        end
    endtask

    task automatic get_exp();
        if (sb.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_underflow got pulse kind %0d want no pulse", kind);
            e.kind = -1; e.flds = '0; e.pay = '0;
        end else e = sb.pop_front();
    endtask

    task automatic clear_counts();
        n_pops = 0; pop_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; my_addr = 16'h0005;
        last_g.kind = 0; last_g.flds = '0; last_g.pay = '0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++; if ({busy, valid, err, drop, rreq} !== 5'b0) begin n_fail++;
            $display("FAIL reset_ctrl got %b want 00000", {busy, valid, err, drop, rreq}); end
        n_cmp++; if ({dst, src, size, dir, typ, psize} !== 62'b0) begin n_fail++;
            $display("FAIL reset_fields got %0h want 0", {dst, src, size, dir, typ, psize}); end
        n_cmp++; if (pay !== '0) begin n_fail++;
            $display("FAIL reset_payload got %0h want 0", pay); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        clear_counts();
        push_frame(16'hFFFF, 16'h0001, 16'd3, 1'b1, 7'h03, 8'hAA, 8'h11, 1'b0);
        en = 1'b1;
        wait_pulse(100, kind, pcyc); get_exp();
        n_cmp++; if (kind !== e.kind) begin n_fail++;
            $display("FAIL t1_kind got %0d want %0d", kind, e.kind); end
        n_cmp++; if ({dst, src, size, dir, typ, psize} !== e.flds) begin n_fail++;
            $display("FAIL t1_fields got %0h want %0h", {dst, src, size, dir, typ, psize}, e.flds); end
        n_cmp++; if (pay !== e.pay || pay[335:312] !== 24'hAABBCC) begin n_fail++;
            $display("FAIL t1_payload got %0h want %0h", pay, e.pay); end
        n_cmp++; if (n_pops !== 10) begin n_fail++;
            $display("FAIL t1_pops got %0d want 10", n_pops); end
        n_cmp++;
        if (pop_cyc.size() < 10) begin n_fail++;
            $display("FAIL t1_timing got %0d pops want 10", pop_cyc.size()); end
        else if (pop_cyc[9] - pop_cyc[0] != 9 || pcyc != pop_cyc[9] + 2) begin n_fail++;
            $display("FAIL t1_timing got span %0d valid_lag %0d want 9 and 2",
                     pop_cyc[9] - pop_cyc[0], pcyc - pop_cyc[9]); end
        @(posedge clk); #2;
        n_cmp++; if ({valid, busy} !== 2'b00 || dst !== 16'hFFFF) begin n_fail++;
            $display("FAIL t1_hold got v/b %b dst %0h want 00 FFFF", {valid, busy}, dst); end
    endtask

    task automatic test_oversize();
        clear_counts();
        push_frame(16'h1234, 16'h0001, 16'h0032, 1'b0, 7'h05, 8'h00, 8'h01, 1'b0);
        wait_pulse(200, kind, pcyc); get_exp();
        n_cmp++; if (kind !== e.kind) begin n_fail++;
            $display("FAIL t3_kind got %0d want %0d", kind, e.kind); end
        n_cmp++; if ({dst, src, size, dir, typ, psize} !== e.flds || pay !== e.pay) begin n_fail++;
            $display("FAIL t3_fields got %0h want %0h", {dst, src, size, dir, typ, psize}, e.flds); end
        n_cmp++; if (n_pops !== 57) begin n_fail++;
            $display("FAIL t3_pops got %0d want 57", n_pops); end
        // size only oversize when all 16 bits are considered
        clear_counts();
        push_frame(16'hFFFF, 16'h0002, 16'h0105, 1'b1, 7'h01, 8'h00, 8'h03, 1'b0);
        wait_pulse(400, kind, pcyc); get_exp();
        n_cmp++; if (kind !== e.kind || n_pops !== 268) begin n_fail++;
            $display("FAIL t3_big got kind %0d pops %0d want %0d 268", kind, n_pops, e.kind); end
        n_cmp++; if ({dst, src, size, dir, typ, psize} !== e.flds) begin n_fail++;
            $display("FAIL t3_big_fields got %0h want %0h", {dst, src, size, dir, typ, psize}, e.flds); end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        my_addr = 16'h0005;
        push_frame(16'h0005, 16'h0002, 16'd0, 1'b0, 7'h03, 8'h00, 8'h00, 1'b0);
        push_frame(16'h0005, 16'h0003, 16'd5, 1'b1, 7'h7F, 8'h10, 8'h03, 1'b0);
        wait_pulse(100, kind, pcyc1); get_exp();
        n_cmp++; if (kind !== e.kind || n_pops !== 7) begin n_fail++;
            $display("FAIL t2_zero got kind %0d pops %0d want %0d 7", kind, n_pops, e.kind); end
        n_cmp++; if ({dst, src, size, dir, typ, psize} !== e.flds || pay !== '0) begin n_fail++;
            $display("FAIL t2_zero_fields got %0h want %0h", {dst, src, size, dir, typ, psize}, e.flds); end
        wait_pulse(100, kind, pcyc); get_exp();
        n_cmp++; if (kind !== e.kind || n_pops !== 19) begin n_fail++;
            $display("FAIL t2_next got kind %0d pops %0d want %0d 19", kind, n_pops, e.kind); end
        n_cmp++; if ({dst, src, size, dir, typ, psize} !== e.flds || pay !== e.pay) begin n_fail++;
            $display("FAIL t2_next_fields got %0h want %0h", {dst, src, size, dir, typ, psize}, e.flds); end
        n_cmp++;
        if (pop_cyc.size() < 8 || pop_cyc[7] != pcyc1 + 1) begin n_fail++;
            $display("FAIL t2_restart got %0d pops want next pop at cycle %0d", pop_cyc.size(), pcyc1 + 1); end
    endtask

    task automatic test_timeout();
        clear_counts();
        stall_at = 4; stall_len = TO; stall_cnt = 0;
        push_frame(16'hFFFF, 16'h0A0A, 16'd6, 1'b0, 7'h01, 8'h20, 8'h01, 1'b1);
        wait_pulse(TO + 50, kind, pcyc); get_exp();
        en = 1'b0;
        n_cmp++; if (kind !== e.kind || n_pops !== 4) begin n_fail++;
            $display("FAIL t4_abort got kind %0d pops %0d want %0d 4", kind, n_pops, e.kind); end
        n_cmp++; if ({dst, src, size, dir, typ, psize} !== e.flds || pay !== e.pay) begin n_fail++;
            $display("FAIL t4_abort_fields got %0h want %0h", {dst, src, size, dir, typ, psize}, e.flds); end
        repeat (3) @(posedge clk);
        #2;
        n_cmp++; if (busy !== 1'b0 || n_pops !== 4) begin n_fail++;
            $display("FAIL t4_idle got busy %b pops %0d want 0 4", busy, n_pops); end
        q.delete();
        clear_counts();
        stall_at = 4; stall_len = TO - 1; stall_cnt = 0;
        push_frame(16'hFFFF, 16'h0B0B, 16'd2, 1'b1, 7'h22, 8'h90, 8'h01, 1'b0);
        en = 1'b1;
        wait_pulse(TO + 50, kind, pcyc); get_exp();
        n_cmp++; if (kind !== e.kind || n_pops !== 9) begin n_fail++;
            $display("FAIL t4_resume got kind %0d pops %0d want %0d 9", kind, n_pops, e.kind); end
        n_cmp++; if ({dst, src, size, dir, typ, psize} !== e.flds || pay !== e.pay) begin n_fail++;
            $display("FAIL t4_resume_fields got %0h want %0h", {dst, src, size, dir, typ, psize}, e.flds); end
        stall_at = -1;
    endtask

    task automatic test_filter();
        logic [15:0] dl [3];
        dl = '{16'h0007, 16'h0009, 16'hFFFF};
        my_addr = 16'h0007;
        clear_counts();
        for (int i = 0; i < 3; i++)
            push_frame(dl[i], 16'h00C0 + 16'(i), 16'd4, 1'b0, 7'h10 + 7'(i), 8'h50, 8'h07, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_pulse(100, kind, pcyc); get_exp();
            n_cmp++; if (kind !== e.kind) begin n_fail++;
                $display("FAIL t5_kind[%0d] got %0d want %0d", i, kind, e.kind); end
            n_cmp++; if ({dst, src, size, dir, typ, psize} !== e.flds || pay !== e.pay) begin n_fail++;
                $display("FAIL t5_fields[%0d] got %0h want %0h", i, {dst, src, size, dir, typ, psize}, e.flds); end
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        push_frame(16'hFFFF, 16'h0D0D, 16'd20, 1'b1, 7'h33, 8'h01, 8'h02, 1'b0);
        void'(sb.pop_back());
        for (int i = 0; i < 60 && n_pops < 14; i++) begin @(posedge clk); #2; end
        rst = 1'b1;
        #1;
        n_cmp++; if ({busy, valid, err, drop, rreq} !== 5'b0 || {dst, src, size, dir, typ, psize} !== 62'b0
                     || pay !== '0) begin n_fail++;
            $display("FAIL t6_async got ctrl %b fields %0h want 0", {busy, valid, err, drop, rreq},
                     {dst, src, size, dir, typ, psize}); end
        last_g.kind = 0; last_g.flds = '0; last_g.pay = '0;
        en = 1'b0; q.delete();
        wait_pulse(5, kind, pcyc);
        n_cmp++; if (kind !== 0) begin n_fail++;
            $display("FAIL t6_no_pulse got kind %0d want 0", kind); end
        rst = 1'b0;
        clear_counts();
        push_frame(16'hFFFF, 16'h00AB, 16'd8, 1'b0, 7'h11, 8'h40, 8'h05, 1'b0);
        en = 1'b1;
        wait_pulse(100, kind, pcyc); get_exp();
        n_cmp++; if (kind !== e.kind || n_pops !== 15) begin n_fail++;
            $display("FAIL t6_after got kind %0d pops %0d want %0d 15", kind, n_pops, e.kind); end
        n_cmp++; if ({dst, src, size, dir, typ, psize} !== e.flds || pay !== e.pay) begin n_fail++;
            $display("FAIL t6_after_fields got %0h want %0h", {dst, src, size, dir, typ, psize}, e.flds); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_oversize();
        test_back_to_back();
        test_timeout();
        test_filter();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
